// File: rtl/score_ssd_driver_pkg.sv
`default_nettype none
// ============================================================================
// score_ssd_driver_pkg : shared conversion states and segment codes
// Revision: 1.0
// ============================================================================
package score_ssd_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam logic [15:0] MAX_SCORE = 16'd9999;
  localparam int          ITER      = 16;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is always off
  localparam logic [7:0] SEG_0     = 8'b00000011;
  localparam logic [7:0] SEG_1     = 8'b10011111;
  localparam logic [7:0] SEG_2     = 8'b00100101;
  localparam logic [7:0] SEG_3     = 8'b00001101;
  localparam logic [7:0] SEG_4     = 8'b10011001;
  localparam logic [7:0] SEG_5     = 8'b01001001;
  localparam logic [7:0] SEG_6     = 8'b01000001;
  localparam logic [7:0] SEG_7     = 8'b00011111;
  localparam logic [7:0] SEG_8     = 8'b00000001;
  localparam logic [7:0] SEG_9     = 8'b00001001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_ssd_driver_bin2bcd_iter.sv
`default_nettype none
// ============================================================================
// bin2bcd_iter : clamped 16-bit binary to 4-digit BCD, one double-dabble step per cycle
// Revision: 1.0
// ============================================================================
module bin2bcd_iter
  import score_ssd_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] bcd
);

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  conv_state_t state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] adj;
  logic [3:0]  iter_q, iter_d;
  logic        ovf_q, ovf_d;

  // Add-3 correction on every BCD nibble before the shift
  always_comb begin
    adj = shreg_q;
    for (int i = 0; i < 4; i++) begin
      if (shreg_q[16 + 4*i +: 4] >= 4'd5) begin
        adj[16 + 4*i +: 4] = shreg_q[16 + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = {16'd0, (bin_in > MAX_SCORE) ? MAX_SCORE : bin_in};
          ovf_d   = (bin_in > MAX_SCORE);
          iter_d  = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = adj << 1;
        iter_d  = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign ovf  = ovf_q;
  assign bcd  = shreg_q[31:16];

endmodule
`default_nettype wire

// File: rtl/score_ssd_driver.sv
`default_nettype none
// ============================================================================
// score_ssd_driver : 4-digit multiplexed seven-segment display of a 16-bit score
// Revision: 1.0
// ============================================================================
module score_ssd_driver
  import score_ssd_driver_pkg::*;
#(
  parameter int SCAN_BITS     = 18,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic [15:0] score,
  output logic [3:0]  An,
  output logic [7:0]  Cathodes,
  output logic        bcd_valid,
  output logic        overflow
);

  localparam int CNT_W = SCAN_BITS + 2;

  logic [CNT_W-1:0] scan_q, scan_d;
  logic [15:0]      last_score_q, last_score_d;
  logic [15:0]      disp_q, disp_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             overflow_q, overflow_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       cath_q, cath_d;

  logic             conv_start, conv_busy, conv_done, conv_ovf;
  logic [15:0]      conv_bcd;
  logic [1:0]       digit;
  logic [3:0]       nib;
  logic [3:1]       lead_zero;
  logic [3:0]       blank_mask;

  // The converter only looks at start while idle, so this is a plain compare
  assign conv_start = !bcd_valid_q || (score != last_score_q);

  bin2bcd_iter u_conv (
    .clk    (ClkPort),
    .rst    (Reset),
    .start  (conv_start),
    .bin_in (score),
    .busy   (conv_busy),
    .done   (conv_done),
    .ovf    (conv_ovf),
    .bcd    (conv_bcd)
  );

  assign digit        = scan_q[CNT_W-1 -: 2];
  assign nib          = disp_q[{digit, 2'b00} +: 4];
  assign lead_zero[3] = (disp_q[15:12] == 4'd0);

  for (genvar k = 1; k < 3; k++) begin : g_lead_zero
    assign lead_zero[k] = lead_zero[k+1] && (disp_q[4*k +: 4] == 4'd0);
  end

  assign blank_mask = BLANK_LEADING ? {lead_zero, 1'b0} : 4'b0000;

  always_comb begin
    scan_d       = scan_q + CNT_W'(1);
    last_score_d = last_score_q;
    disp_d       = disp_q;
    overflow_d   = overflow_q;
    bcd_valid_d  = bcd_valid_q;
    if (conv_start && !conv_busy) begin
      last_score_d = score;
    end
    if (conv_done) begin
      disp_d      = conv_bcd;
      overflow_d  = conv_ovf;
      bcd_valid_d = 1'b1;
    end
    an_d   = ~(4'b0001 << digit);
    cath_d = (!bcd_valid_q || blank_mask[digit]) ? SEG_BLANK : seg_decode(nib);
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      scan_q       <= '0;
      last_score_q <= '0;
      disp_q       <= '0;
      bcd_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      an_q         <= 4'hF;
      cath_q       <= SEG_BLANK;
    end else begin
      scan_q       <= scan_d;
      last_score_q <= last_score_d;
      disp_q       <= disp_d;
      bcd_valid_q  <= bcd_valid_d;
      overflow_q   <= overflow_d;
      an_q         <= an_d;
      cath_q       <= cath_d;
    end
  end

  assign An        = an_q;
  assign Cathodes  = cath_q;
  assign bcd_valid = bcd_valid_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: doc/score_ssd_driver.md
SCORE_SSD_DRIVER -- requirements
Module: score_ssd_driver

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 18, meaning log2 of the clock cycles each digit is lit (2^18 cycles = 2.62 ms at 100 MHz).
REQ-002 SHALL have parameter BLANK_LEADING, default 1, meaning leading-zero digits are blanked when 1.
REQ-003 SHALL have port ClkPort, input, 1 bit: system clock, 100 MHz.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port score, input, 16 bits: unsigned binary score from Game_Logic, sampled on ClkPort.
REQ-006 SHALL have port An, output, 4 bits: active-low digit anodes; An[0] is the rightmost digit.
REQ-007 SHALL have port Cathodes, output, 8 bits: active-low segments in the order {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.
REQ-008 SHALL have port bcd_valid, output, 1 bit: high once the first conversion has been committed after reset.
REQ-009 SHALL have port overflow, output, 1 bit: high when the displayed value was clamped.

Function
REQ-010 SHALL run a conversion FSM with states IDLE, SHIFT and DONE.
REQ-011 IDLE SHALL go to SHIFT when bcd_valid=0 or score differs from last_score, capturing min(score, 9999) into the shift register and the raw score into last_score.
REQ-012 SHALL set the pending overflow flag in the capture cycle when score > 9999.
REQ-013 SHIFT SHALL perform one double-dabble iteration per cycle for exactly 16 cycles; each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1.
REQ-014 DONE SHALL, for one cycle, load the four display nibbles, update overflow, set bcd_valid=1 and return to IDLE.
REQ-015 Latency SHALL be 18 cycles: a score change seen in IDLE at cycle N appears in the display register at cycle N+18.
REQ-016 Score changes during SHIFT/DONE SHALL be ignored; IDLE re-compares afterwards, giving at most one extra conversion.
REQ-017 The display register SHALL change only in DONE, so no partially converted value is ever shown.
REQ-018 SHALL have a free-running scan counter of SCAN_BITS+2 bits whose top 2 bits select digit d (0..3).
REQ-019 An SHALL drive ~(1<<d), giving exactly one anode low at any time after reset.
REQ-020 Segment codes SHALL be: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001.
REQ-021 Dp SHALL always be 1 (off).
REQ-022 With BLANK_LEADING=1, digit d>0 SHALL show 8'hFF when its nibble and all higher nibbles are 0; digit 0 SHALL always be shown.
REQ-023 While bcd_valid=0, Cathodes SHALL be 8'hFF for all digits.
REQ-024 Anodes and Cathodes SHALL be registered, adding 1 cycle of latency to the scan.

Reset
REQ-025 On Reset=1, asynchronously: An=4'hF, Cathodes=8'hFF, bcd_valid=0, overflow=0, FSM=IDLE, scan counter=0, display nibbles=0, last_score=0.
REQ-026 Reset asserted mid-conversion SHALL abort it; after release, a fresh conversion SHALL start on the first cycle because bcd_valid=0.

Structure
REQ-027 The shared package SHALL hold the FSM state enum, the segment-code constants for 0-9 and blank, MAX_SCORE=9999 and ITER=16.
REQ-028 The double-dabble datapath and FSM SHALL be a sub-module named bin2bcd_iter (handshake: start/busy/done, bcd[15:0]).
REQ-029 The scan, blanking and decode logic SHALL live in score_ssd_driver itself.

Verification (SCAN_BITS=2 in sim)
REQ-030 Reset release with score=0: bcd_valid rises on cycle 18; digit0 Cathodes=00000011; digits 1-3 =8'hFF; An cycles E,D,B,7 every 4 cycles.
REQ-031 score=1234: after 18 cycles, digits 3..0 show 10011111, 00100101, 00001101, 10011001; overflow=0.
REQ-032 score=12000: display shows 9999 (all digits 00001001) and overflow=1; then score=5: display shows 5 on digit0, others blank, overflow=0.
REQ-033 score changes 0042 -> 0043 at SHIFT cycle 5: 0042 is committed first, then 0043 is committed 18 cycles after IDLE is re-entered; no other value ever appears.
REQ-034 Reset pulsed during SHIFT: outputs go to their reset values immediately; after release the current score is displayed within 18 cycles.
REQ-035 BLANK_LEADING=0, score=7: displays 0007 with digits 3..1 = 00000011.
